int_mul_recon: RTL and testbench

INT_MUL_RECON -- requirements
Module: int_mul_recon

---
 rtl/int_div_pkg.sv | 14 +
 rtl/int_mul_recon_if.sv | 41 ++++
 rtl/int_mul_step.sv | 24 ++
 rtl/int_mul_recon.sv | 94 +++++++++
 tb/tb_int_mul_recon.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/int_div_pkg.sv
// int_div_pkg: constants and FSM state type shared by the integer divider
// and its inverse, the multiply-reconstruct block (int_mul_recon).
// Optional feature macro used by the consumers: INT_MUL_RECON_CHECK_EN.
package int_div_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/int_mul_recon_if.sv
// int_mul_recon_if: request/result bundle for int_mul_recon.
// Macro INT_MUL_RECON_CHECK_EN adds the 'invalid' result flag.
interface int_mul_recon_if
    import int_div_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) ();

    logic                 start;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     remainder;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
`ifdef INT_MUL_RECON_CHECK_EN
    logic                 invalid;

    modport master (
        output start, quotient, divisor, remainder,
        input  busy, done, product, invalid
    );

    modport slave (
        input  start, quotient, divisor, remainder,
        output busy, done, product, invalid
    );
`else

    modport master (
        output start, quotient, divisor, remainder,
        input  busy, done, product
    );

    modport slave (
        input  start, quotient, divisor, remainder,
        output busy, done, product
    );
`endif

endinterface

// File: rtl/int_mul_step.sv
// int_mul_step: one shift-add step of the multiply-reconstruct datapath.
// Adds the multiplicand shifted left by the step index when the quotient bit is set.
module int_mul_step
    import int_div_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned CW    = 3
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    input  logic               qbit,
    input  logic [CW-1:0]      index,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [2*WIDTH-1:0] addend;

    // Conditional add of the weighted partial product
    always_comb begin
        addend   = {{WIDTH{1'b0}}, mcand} << index;
        acc_next = qbit ? (acc + addend) : acc;
    end

endmodule

// File: rtl/int_mul_recon.sv
// int_mul_recon: reconstructs a dividend as quotient*divisor+remainder using
// a WIDTH-cycle LSB-first shift-add loop (IDLE -> RUN x WIDTH -> DONE).
// Macro INT_MUL_RECON_CHECK_EN adds the registered 'invalid' operand flag.
module int_mul_recon
    import int_div_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    int_mul_recon_if.slave  bus
);

    localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state;
    logic [WIDTH-1:0]  q_r;
    logic [WIDTH-1:0]  d_r;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     acc_next;
    logic [PW-1:0]     prod_r;
    logic [CW-1:0]     cnt;

    int_mul_step #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_step (
        .acc      (acc),
        .mcand    (d_r),
        .qbit     (q_r[cnt]),
        .index    (cnt),
        .acc_next (acc_next)
    );

    // FSM, operand capture, accumulation and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q_r    <= '0;
            d_r    <= '0;
            acc    <= '0;
            prod_r <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= RUN;
                        q_r   <= bus.quotient;
                        d_r   <= bus.divisor;
                        acc   <= {{WIDTH{1'b0}}, bus.remainder};
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= DONE;
                        prod_r <= acc_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef INT_MUL_RECON_CHECK_EN
    logic invalid_r;

    // Operand sanity flag, captured alongside the operands
    always_ff @(posedge clk) begin
        if (rst) begin
            invalid_r <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            invalid_r <= (bus.remainder >= bus.divisor) || (bus.divisor == '0);
        end
    end

    assign bus.invalid = invalid_r;
`endif

    assign bus.busy    = (state == RUN) || (state == DONE);
    assign bus.done    = (state == DONE);
    assign bus.product = prod_r;

endmodule

// File: tb/tb_int_mul_recon.sv
// tb_int_mul_recon: directed and randomized checks of int_mul_recon against
// an arithmetic reference (q*d+r, fixed WIDTH+1 cycle completion latency).
module tb_int_mul_recon;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    int_mul_recon_if #(.WIDTH(W)) bus ();

    int_mul_recon #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [63:0] ref_prod(input logic [W-1:0] q, input logic [W-1:0] d,
                                             input logic [W-1:0] r);
        longint unsigned p;
        p = longint'(q) * longint'(d) + longint'(r);
        return p;
    endfunction

    function automatic logic [63:0] ref_invalid(input logic [W-1:0] d, input logic [W-1:0] r);
        return (r >= d || d == 0) ? 64'd1 : 64'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        bus.quotient  = W'($urandom);
        bus.divisor   = W'($urandom);
        bus.remainder = W'($urandom);
    endtask

    // One operation; with scramble set, inputs and start toggle randomly while busy
    task automatic do_op(input string tag, input logic [W-1:0] q, input logic [W-1:0] d,
                         input logic [W-1:0] r, input bit scramble);
        int          cycles;
        logic [63:0] exp;
        logic [63:0] prev;
        exp  = ref_prod(q, d, r);
        prev = 64'(bus.product);
        bus.start     = 1'b1;
        bus.quotient  = q;
        bus.divisor   = d;
        bus.remainder = r;
        tick();
        cycles = 1;
        check({tag, " busy"}, 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && cycles < 40) begin
            if (scramble) begin
                randomize_inputs();
                bus.start = 1'($urandom);
            end
            if (cycles == 4) check({tag, " hold"}, 64'(bus.product), prev);
            tick();
            cycles++;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 64'(cycles), 64'(W + 1));
        check({tag, " product"}, 64'(bus.product), exp);
`ifdef INT_MUL_RECON_CHECK_EN
        check({tag, " invalid"}, 64'(bus.invalid), ref_invalid(d, r));
`endif
        tick();
        check({tag, " done pulse"}, 64'({bus.done, bus.busy}), 64'd0);
        check({tag, " retain"}, 64'(bus.product), exp);
    endtask

    initial begin
        int          cycles;
        int          dones;
        logic [W-1:0] q;
        logic [W-1:0] d;
        logic [W-1:0] r;

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.quotient  = '0;
        bus.divisor   = '0;
        bus.remainder = '0;
        tick();
        tick();
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset product", 64'(bus.product), 64'd0);
`ifdef INT_MUL_RECON_CHECK_EN
        check("reset invalid", 64'(bus.invalid), 64'd0);
`endif
        rst = 1'b0;
        tick();

        do_op("basic 7*9+3", 8'd7, 8'd9, 8'd3, 1'b0);
        check("basic value 66", 64'(bus.product), 64'd66);
        do_op("max", 8'd255, 8'd255, 8'd254, 1'b0);
        check("max value 0xFEFF", 64'(bus.product), 64'hFEFF);
        do_op("zero", 8'd0, 8'd0, 8'd0, 1'b0);

        // Start while busy is ignored; start in DONE ignored; start in following IDLE accepted
        bus.start = 1'b1; bus.quotient = 8'd3; bus.divisor = 8'd4; bus.remainder = 8'd1;
        tick();
        cycles = 1;
        dones  = 0;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && cycles < 40) begin
            bus.start = (cycles == 3);
            if (cycles == 3) begin
                bus.quotient = 8'd10; bus.divisor = 8'd10; bus.remainder = 8'd0;
            end
            tick();
            cycles++;
        end
        check("busy-start latency", 64'(cycles), 64'(W + 1));
        check("busy-start product", 64'(bus.product), 64'd13);
        bus.start = 1'b1; bus.quotient = 8'd1; bus.divisor = 8'd1; bus.remainder = 8'd0;
        tick();
        check("done-start ignored", 64'({bus.busy, bus.done}), 64'd0);
        do_op("after done", 8'd2, 8'd3, 8'd4, 1'b0);

        // Reset in the middle of RUN aborts without a done pulse
        bus.start = 1'b1; bus.quotient = 8'd9; bus.divisor = 8'd9; bus.remainder = 8'd9;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort product", 64'(bus.product), 64'd0);
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) dones++;
            tick();
        end
        check("abort no done", 64'(dones), 64'd0);
        do_op("after abort", 8'd2, 8'd5, 8'd1, 1'b0);
        check("after abort value 11", 64'(bus.product), 64'd11);

        // Reset wins over a simultaneous start
        rst = 1'b1; bus.start = 1'b1;
        tick();
        rst = 1'b0; bus.start = 1'b0;
        check("rst over start", 64'(bus.busy), 64'd0);
        tick();

        do_op("inv r=d", 8'd1, 8'd5, 8'd5, 1'b0);
        check("inv r=d value", 64'(bus.product), 64'd10);
        do_op("inv r<d", 8'd1, 8'd5, 8'd4, 1'b0);
        check("inv r<d value", 64'(bus.product), 64'd9);

        for (int i = 0; i < 24; i++) begin
            q = W'($urandom);
            d = W'($urandom);
            r = W'($urandom);
            do_op($sformatf("rand%0d", i), q, d, r, (i % 2) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
